bit32_1to3_demux: RTL and testbench
===================================

Name: bit32_1to3_demux

Overview:
- Registered 1-to-3 stream demultiplexer. It is the inverse of the 32-bit 3-to-1 mux.
- One 32-bit input stream carries a 2-bit select. Each beat is steered into one of three single-entry output buffers, and each buffer presents its beat on a valid/ready output channel.
- Sits between a single producer, such as the ALU/writeback path, and three consumers.
- Beats with an invalid select are dropped and counted.

Parameters:
- WIDTH, 32, data width of input and all outputs.
- ERRW, 8, width of the saturating invalid-select counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input beat present.
- IN_READY  output  1  demux accepts the input beat this cycle.
- IN_SEL  input  2  destination: 00 -> OUT0, 01 -> OUT1, 10 -> OUT2, 11 invalid.
- IN_DATA  input  WIDTH  input payload.
- OUT0_VALID / OUT1_VALID / OUT2_VALID  output  1  channel buffer holds a beat.
- OUT0_READY / OUT1_READY / OUT2_READY  input  1  consumer takes the beat.
- OUT0_DATA / OUT1_DATA / OUT2_DATA  output  WIDTH  channel buffer contents.
- ERR_CNT  output  ERRW  number of invalid-select beats dropped; saturates.

Behaviour:
- Reset (rst_n low, asynchronous): all OUTn_VALID = 0, all OUTn_DATA = 0, ERR_CNT = 0. Reset mid-transfer discards buffered beats; no beat is emitted after reset is released until a new input is accepted.
- Per channel n, each has one buffer with two states, EMPTY and FULL.
  - EMPTY -> FULL when an input is accepted with IN_SEL = n.
  - FULL -> EMPTY when OUTn_READY is high and no new beat for n is accepted.
  - FULL -> FULL with new data when OUTn_READY is high and a beat for n is accepted in the same cycle (drain and refill).
- Input handshake:
  - For sel n in {0,1,2}: IN_READY = !OUTn_VALID || OUTn_READY. This is combinational from OUTn_READY.
  - For sel 11: IN_READY = 1. The beat is dropped and ERR_CNT increments unless it is already at all-ones.
  - Transfer occurs on the edge where IN_VALID && IN_READY.
- Latency: accepted beat appears on OUTn_DATA with OUTn_VALID = 1 the cycle after acceptance. Sustained throughput is 1 beat/cycle to any channel whose consumer keeps READY high.
- Output stability: while OUTn_VALID && !OUTn_READY, OUTn_DATA holds constant.
- Independence: a stalled channel blocks only input beats selecting it; beats for other channels still flow. Ordering is preserved per channel only.
- IN_SEL and IN_DATA are ignored when IN_VALID = 0. ERR_CNT counts only accepted invalid beats.
- Output data of an EMPTY channel holds its last value and is don't-care to consumers.
- No combinational path from IN_DATA to any output.

Decomposition:
- Shared package holds:
  - select encodings SEL_CH0 = 2'b00, SEL_CH1 = 2'b01, SEL_CH2 = 2'b10, SEL_BAD = 2'b11;
  - default WIDTH and ERRW.
- Natural sub-module: demux_slot, a single-entry valid/ready buffer with load, data-in, ready-in, valid-out and data-out. The top instantiates three demux_slot blocks plus the select decode and the ERR_CNT logic.

Test Plan:
1. Reset check: assert rst_n = 0 mid-simulation with OUT1 FULL -> on the same cycle OUT1_VALID = 0, all OUTn_DATA = 0, ERR_CNT = 0.
2. Basic routing: all OUTn_READY = 1, send sel 00 data 3, sel 01 data 4, sel 10 data 2 on consecutive cycles -> OUT0_DATA = 3, OUT1_DATA = 4, OUT2_DATA = 2, each valid exactly one cycle, one cycle after its input.
3. Backpressure: OUT0_READY = 0, send sel 00 data 5 then sel 00 data 6 -> OUT0_DATA stays 5, IN_READY = 0 for the second beat. Raise OUT0_READY -> 5 consumed, then 6 appears the next cycle, with no loss or duplication.
4. Non-blocking: OUT0 stalled and FULL, send sel 10 data 9 -> IN_READY = 1, OUT2_DATA = 9 next cycle while OUT0 still holds its beat.
5. Invalid select: send 3 beats with sel 11 -> IN_READY = 1 each cycle, no OUTn_VALID rises, ERR_CNT = 3. Drive 300 invalid beats -> ERR_CNT saturates at 255.
6. Drain and refill: OUT1 FULL with data 7, OUT1_READY = 1, same cycle accept sel 01 data 8 -> OUT1_VALID stays 1, OUT1_DATA = 8 next cycle, 7 counted as consumed once.

Source files
------------

// File: rtl/bit32_1to3_demux_pkg.sv
// ---------------------------------------------------------------------------
// bit32_1to3_demux_pkg
//   Shared definitions for the 1-to-3 stream demultiplexer:
//     - select encodings carried on IN_SEL
//     - default data width and error-counter width
//     - per-channel buffer state type
// ---------------------------------------------------------------------------
package bit32_1to3_demux_pkg;

    // Destination encodings carried on IN_SEL
    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    // Default sizes
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_ERRW  = 8;

    // Single-entry channel buffer occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : bit32_1to3_demux_pkg

// File: rtl/bit32_1to3_demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
//   Single-entry valid/ready output buffer for one demux channel.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset (clears state and data)
//     load   in   accept a beat into the buffer this cycle; the parent only
//                 asserts it when the buffer is empty or being drained
//     din    in   WIDTH  beat payload
//     ready  in   consumer takes the buffered beat this cycle
//     valid  out  buffer holds a beat
//     dout   out  WIDTH  buffered payload (holds last value when empty)
// ---------------------------------------------------------------------------
module demux_slot
    import bit32_1to3_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    slot_state_t state, state_nxt;
    logic [WIDTH-1:0] data_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a load always leaves the slot FULL (fill or drain+refill);
    // otherwise a taken beat empties it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_nxt = SLOT_FULL;
                end else if (ready) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
            default: state_nxt = SLOT_EMPTY;
        endcase
    end

    // Payload register: only written on load, so it is stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end
    end

    assign valid = (state == SLOT_FULL);
    assign dout  = data_q;

endmodule : demux_slot

// File: rtl/bit32_1to3_demux.sv
// ---------------------------------------------------------------------------
// bit32_1to3_demux
//   Registered 1-to-3 stream demultiplexer. Each accepted input beat is
//   steered by IN_SEL into one of three single-entry output buffers; beats
//   with IN_SEL = 11 are accepted, dropped and counted in ERR_CNT.
//
//   Ports:
//     clk                  in   clock, rising edge
//     rst_n                in   asynchronous active-low reset
//     IN_VALID             in   input beat present
//     IN_READY             out  input beat accepted this cycle
//     IN_SEL               in   2     00->OUT0, 01->OUT1, 10->OUT2, 11 dropped
//     IN_DATA              in   WIDTH input payload
//     OUTn_VALID (n=0..2)  out  channel buffer holds a beat
//     OUTn_READY (n=0..2)  in   consumer takes the beat
//     OUTn_DATA  (n=0..2)  out  WIDTH channel buffer contents
//     ERR_CNT              out  ERRW  saturating count of dropped beats
// ---------------------------------------------------------------------------
module bit32_1to3_demux
    import bit32_1to3_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ERRW  = DEF_ERRW
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_SEL,
    input  logic [WIDTH-1:0] IN_DATA,

    output logic             OUT0_VALID,
    input  logic             OUT0_READY,
    output logic [WIDTH-1:0] OUT0_DATA,

    output logic             OUT1_VALID,
    input  logic             OUT1_READY,
    output logic [WIDTH-1:0] OUT1_DATA,

    output logic             OUT2_VALID,
    input  logic             OUT2_READY,
    output logic [WIDTH-1:0] OUT2_DATA,

    output logic [ERRW-1:0]  ERR_CNT
);

    logic       accept;
    logic [2:0] load;
    logic       bad_beat;
    logic [ERRW-1:0] err_q;

    // Ready depends only on the addressed channel, so a stalled channel
    // blocks only beats selecting it. Invalid selects are always sunk.
    always_comb begin
        IN_READY = 1'b1;
        case (IN_SEL)
            SEL_CH0: IN_READY = !OUT0_VALID || OUT0_READY;
            SEL_CH1: IN_READY = !OUT1_VALID || OUT1_READY;
            SEL_CH2: IN_READY = !OUT2_VALID || OUT2_READY;
            default: IN_READY = 1'b1;
        endcase
    end

    always_comb begin
        accept   = IN_VALID && IN_READY;
        load     = '0;
        load[0]  = accept && (IN_SEL == SEL_CH0);
        load[1]  = accept && (IN_SEL == SEL_CH1);
        load[2]  = accept && (IN_SEL == SEL_CH2);
        bad_beat = accept && (IN_SEL == SEL_BAD);
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[0]),
        .din   (IN_DATA),
        .ready (OUT0_READY),
        .valid (OUT0_VALID),
        .dout  (OUT0_DATA)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[1]),
        .din   (IN_DATA),
        .ready (OUT1_READY),
        .valid (OUT1_VALID),
        .dout  (OUT1_DATA)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[2]),
        .din   (IN_DATA),
        .ready (OUT2_READY),
        .valid (OUT2_VALID),
        .dout  (OUT2_DATA)
    );

    // Saturating count of dropped invalid-select beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (bad_beat && (err_q != '1)) begin
            err_q <= err_q + {{(ERRW-1){1'b0}}, 1'b1};
        end
    end

    assign ERR_CNT = err_q;

endmodule : bit32_1to3_demux

// File: tb/tb_bit32_1to3_demux.sv
// ---------------------------------------------------------------------------
// tb_bit32_1to3_demux
//   Directed stimulus with a per-channel scoreboard. The driver pushes the
//   expected payload when a beat is accepted; the monitor pops and compares
//   whenever a channel presents a beat.
// ---------------------------------------------------------------------------
module tb_bit32_1to3_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'b00;
    logic [31:0] in_data = '0;
    logic        o0_valid, o1_valid, o2_valid;
    logic        o0_ready = 1'b1, o1_ready = 1'b1, o2_ready = 1'b1;
    logic [31:0] o0_data, o1_data, o2_data;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    bit32_1to3_demux #(.WIDTH(32), .ERRW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .IN_SEL     (in_sel),
        .IN_DATA    (in_data),
        .OUT0_VALID (o0_valid),
        .OUT0_READY (o0_ready),
        .OUT0_DATA  (o0_data),
        .OUT1_VALID (o1_valid),
        .OUT1_READY (o1_ready),
        .OUT1_DATA  (o1_data),
        .OUT2_VALID (o2_valid),
        .OUT2_READY (o2_ready),
        .OUT2_DATA  (o2_data),
        .ERR_CNT    (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted; returns cycles waited.
    task automatic send(input logic [1:0] s, input logic [31:0] d, output int waits);
        logic got;
        got      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        if (!got) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            case (s)
                2'd0: q0.push_back(d);
                2'd1: q1.push_back(d);
                2'd2: q2.push_back(d);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every presented beat must match the channel's queue head;
    // a taken beat retires the head.
    always @(negedge clk) begin
        logic        v, r;
        logic [31:0] d;
        int          sz;
        logic [31:0] front;
        if (rst_n) begin
            for (int n = 0; n < 3; n++) begin
                front = '0;
                case (n)
                    0: begin v = o0_valid; r = o0_ready; d = o0_data; sz = q0.size(); if (sz > 0) front = q0[0]; end
                    1: begin v = o1_valid; r = o1_ready; d = o1_data; sz = q1.size(); if (sz > 0) front = q1[0]; end
                    default: begin v = o2_valid; r = o2_ready; d = o2_data; sz = q2.size(); if (sz > 0) front = q2[0]; end
                endcase
                if (v) begin
                    total++;
                    if (sz == 0) begin
                        bad++;
                        $display("FAIL mon_ch%0d_spurious: got data %0h expected no beat", n, d);
                    end else begin
                        if (d !== front) begin
                            bad++;
                            $display("FAIL mon_ch%0d_data: got %0h expected %0h", n, d, front);
                        end
                        if (r) begin
                            case (n)
                                0: void'(q0.pop_front());
                                1: void'(q1.pop_front());
                                default: void'(q2.pop_front());
                            endcase
                        end
                    end
                end
            end
        end
    end

    initial begin
        int w;

        // Reset values
        #2;
        check("rst_v0", {31'd0, o0_valid}, 32'd0);
        check("rst_v1", {31'd0, o1_valid}, 32'd0);
        check("rst_v2", {31'd0, o2_valid}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        check("rst_d0", o0_data, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Basic routing, consumers always ready
        send(2'd0, 32'd3, w);
        check("route_o0_valid", {31'd0, o0_valid}, 32'd1);
        check("route_o0_data", o0_data, 32'd3);
        send(2'd1, 32'd4, w);
        check("route_o1_data", o1_data, 32'd4);
        send(2'd2, 32'd2, w);
        check("route_o2_data", o2_data, 32'd2);
        check("route_o0_one_cycle", {31'd0, o0_valid}, 32'd0);
        check("route_o1_one_cycle", {31'd0, o1_valid}, 32'd0);
        tick();
        check("route_o2_one_cycle", {31'd0, o2_valid}, 32'd0);

        // Backpressure on OUT0
        o0_ready = 1'b0;
        send(2'd0, 32'd5, w);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'd6;
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
        check("bp_hold", o0_data, 32'd5);
        tick();
        o0_ready = 1'b1;
        send(2'd0, 32'd6, w);
        check("bp_second_data", o0_data, 32'd6);
        check("bp_second_valid", {31'd0, o0_valid}, 32'd1);
        tick();
        check("bp_drained", {31'd0, o0_valid}, 32'd0);

        // Non-blocking: OUT0 stalled, OUT2 still flows
        o0_ready = 1'b0;
        send(2'd0, 32'h0000_000A, w);
        send(2'd2, 32'd9, w);
        check("nb_no_wait", w, 32'd0);
        check("nb_o2_data", o2_data, 32'd9);
        check("nb_o2_valid", {31'd0, o2_valid}, 32'd1);
        check("nb_o0_held", o0_data, 32'h0000_000A);
        check("nb_o0_valid", {31'd0, o0_valid}, 32'd1);
        tick();
        o0_ready = 1'b1;
        tick();
        tick();

        // Drain and refill on OUT1
        o1_ready = 1'b0;
        send(2'd1, 32'd7, w);
        o1_ready = 1'b1;
        send(2'd1, 32'd8, w);
        check("dr_no_wait", w, 32'd0);
        check("dr_valid", {31'd0, o1_valid}, 32'd1);
        check("dr_data", o1_data, 32'd8);
        tick();
        check("dr_drained", {31'd0, o1_valid}, 32'd0);
        check("dr_q1_empty", q1.size(), 32'd0);

        // Invalid selects: always accepted, never routed, counted
        for (int i = 0; i < 3; i++) begin
            send(2'd3, 32'hDEAD_0000 + i, w);
            check("bad_in_ready", w, 32'd0);
        end
        check("bad_err3", {24'd0, err_cnt}, 32'd3);
        check("bad_no_v0", {31'd0, o0_valid}, 32'd0);
        for (int i = 0; i < 252; i++) send(2'd3, 32'h0, w);
        check("bad_err255", {24'd0, err_cnt}, 32'd255);
        for (int i = 0; i < 48; i++) send(2'd3, 32'h0, w);
        check("bad_err_sat", {24'd0, err_cnt}, 32'd255);
        // Idle with a bad select present must not count
        in_sel = 2'd3;
        tick();
        tick();

        // Asynchronous reset with OUT1 full
        o1_ready = 1'b0;
        send(2'd1, 32'h0000_0011, w);
        check("pre_rst_o1_valid", {31'd0, o1_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        q1.delete();
        check("arst_o1_valid", {31'd0, o1_valid}, 32'd0);
        check("arst_d0", o0_data, 32'd0);
        check("arst_d1", o1_data, 32'd0);
        check("arst_d2", o2_data, 32'd0);
        check("arst_err", {24'd0, err_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        o1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", {31'd0, o1_valid}, 32'd0);
        end

        check("end_q0", q0.size(), 32'd0);
        check("end_q1", q1.size(), 32'd0);
        check("end_q2", q2.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_bit32_1to3_demux
